regfile_scoreboard: RTL and testbench

- 32 x 64-bit integer register file that receives the writeback stage's write data and serves two combinational read ports to decode.
- Also tracks pending writes per register, so decode can detect RAW hazards before issuing.
- Sits between decode/issue (reads, destination reservations) and writeback (rf_wr_data producer).

---
 rtl/regfile_scoreboard_if.sv | 36 +++
 rtl/regfile_scoreboard.sv | 107 ++++++++++
 tb/tb_regfile_scoreboard.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_scoreboard_if.sv
// Bundle of the decode-side read/reserve signals and the writeback write
// port of regfile_scoreboard.
//   master : decode/issue + writeback (drives addresses, reservations, writes)
//   slave  : regfile_scoreboard (returns read data, busy, stall, error)
interface regfile_scoreboard_if #(
  parameter int XLEN = 64,
  parameter int AW   = 5
);
  logic [AW-1:0]   rs1_addr_i;
  logic [AW-1:0]   rs2_addr_i;
  logic [XLEN-1:0] rs1_data_o;
  logic [XLEN-1:0] rs2_data_o;
  logic            rs1_busy_o;
  logic            rs2_busy_o;
  logic            issue_valid_i;
  logic [AW-1:0]   issue_rd_i;
  logic            issue_stall_o;
  logic            wr_en_i;
  logic [AW-1:0]   wr_addr_i;
  logic [XLEN-1:0] wr_data_i;
  logic            wb_err_o;

  modport master (
    output rs1_addr_i, rs2_addr_i, issue_valid_i, issue_rd_i,
           wr_en_i, wr_addr_i, wr_data_i,
    input  rs1_data_o, rs2_data_o, rs1_busy_o, rs2_busy_o,
           issue_stall_o, wb_err_o
  );

  modport slave (
    input  rs1_addr_i, rs2_addr_i, issue_valid_i, issue_rd_i,
           wr_en_i, wr_addr_i, wr_data_i,
    output rs1_data_o, rs2_data_o, rs1_busy_o, rs2_busy_o,
           issue_stall_o, wb_err_o
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Integer register file (x0 hardwired to zero) with two combinational,
// write-bypassed read ports and a per-register pending-write counter used by
// decode to detect RAW hazards.
// Ports:
//   clk    : clock, rising edge
//   resetn : asynchronous active-low reset
//   rf     : regfile_scoreboard_if.slave
//            rsN_addr_i / rsN_data_o / rsN_busy_o : read ports
//            issue_valid_i / issue_rd_i / issue_stall_o : destination reservation
//            wr_en_i / wr_addr_i / wr_data_i : writeback port
//            wb_err_o : sticky "write without reservation" flag
module regfile_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int XLEN     = 64,
  parameter int CNT_W    = 2
) (
  input  logic                  clk,
  input  logic                  resetn,
  regfile_scoreboard_if.slave   rf
);

  localparam int AW = $clog2(NUM_REGS);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  logic [XLEN-1:0]  regs_q [NUM_REGS];
  logic [CNT_W-1:0] cnt_q  [NUM_REGS];
  logic [CNT_W-1:0] cnt_d  [NUM_REGS];
  logic             wb_err_q, wb_err_d;

  logic             wr_live;
  logic             hit1, hit2;
  logic             stall;
  logic             inc, dec;

  // A write to x0 is treated as no write at all.
  assign wr_live = rf.wr_en_i && (rf.wr_addr_i != '0);
  assign hit1    = wr_live && (rf.wr_addr_i == rf.rs1_addr_i);
  assign hit2    = wr_live && (rf.wr_addr_i == rf.rs2_addr_i);

  // Read ports: x0 reads zero, a same-cycle write is forwarded.
  always_comb begin
    rf.rs1_data_o = '0;
    if (rf.rs1_addr_i != '0) begin
      rf.rs1_data_o = hit1 ? rf.wr_data_i : regs_q[rf.rs1_addr_i];
    end
    rf.rs2_data_o = '0;
    if (rf.rs2_addr_i != '0) begin
      rf.rs2_data_o = hit2 ? rf.wr_data_i : regs_q[rf.rs2_addr_i];
    end
  end

  // Busy clears on a bypass hit only when that write is the last one pending;
  // with more outstanding, a younger value is still on its way.
  assign rf.rs1_busy_o = (rf.rs1_addr_i != '0) && (cnt_q[rf.rs1_addr_i] != CNT_ZERO) &&
                         !(hit1 && (cnt_q[rf.rs1_addr_i] == CNT_ONE));
  assign rf.rs2_busy_o = (rf.rs2_addr_i != '0) && (cnt_q[rf.rs2_addr_i] != CNT_ZERO) &&
                         !(hit2 && (cnt_q[rf.rs2_addr_i] == CNT_ONE));

  // A saturated counter refuses the reservation unless a same-cycle write
  // to that register frees a slot.
  assign stall = rf.issue_valid_i && (rf.issue_rd_i != '0) &&
                 (cnt_q[rf.issue_rd_i] == CNT_MAX) &&
                 !(wr_live && (rf.wr_addr_i == rf.issue_rd_i));
  assign rf.issue_stall_o = stall;

  always_comb begin
    inc = 1'b0;
    dec = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) begin
      cnt_d[r] = cnt_q[r];
    end
    for (int r = 1; r < NUM_REGS; r++) begin
      inc = rf.issue_valid_i && (rf.issue_rd_i == AW'(r)) && !stall;
      dec = rf.wr_en_i && (rf.wr_addr_i == AW'(r)) && (cnt_q[r] != CNT_ZERO);
      if (inc && !dec) begin
        cnt_d[r] = cnt_q[r] + CNT_ONE;
      end else if (dec && !inc) begin
        cnt_d[r] = cnt_q[r] - CNT_ONE;
      end
    end
  end

  // Unreserved write: the data still lands, the counter stays at zero.
  assign wb_err_d = wb_err_q || (wr_live && (cnt_q[rf.wr_addr_i] == CNT_ZERO));
  assign rf.wb_err_o = wb_err_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs_q[r] <= '0;
        cnt_q[r]  <= '0;
      end
      wb_err_q <= 1'b0;
    end else begin
      if (wr_live) begin
        regs_q[rf.wr_addr_i] <= rf.wr_data_i;
      end
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      wb_err_q <= wb_err_d;
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
module tb_regfile_scoreboard;

  logic clk = 1'b0;
  logic resetn;

  always #5 clk = ~clk;

  regfile_scoreboard_if bus ();

  regfile_scoreboard dut (
    .clk    (clk),
    .resetn (resetn),
    .rf     (bus)
  );

  localparam logic [63:0] V7  = 64'hDEAD_BEEF_0000_1234;
  localparam logic [63:0] V3  = 64'h0000_0000_0000_0033;
  localparam logic [63:0] V12 = 64'h0123_4567_89AB_CDEF;

  // Observation vector: {rs1_data, rs1_busy, rs2_data, rs2_busy, stall, err}
  typedef struct {
    logic        rstn;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic        iv;
    logic [4:0]  ird;
    logic        we;
    logic [4:0]  wa;
    logic [63:0] wd;
    logic [131:0] exp;
  } vec_t;

  typedef struct {
    string        tag;
    logic [131:0] exp;
  } sb_t;

  sb_t sb[$];
  int  n_chk  = 0;
  int  n_pass = 0;

  function automatic logic [131:0] ex(input logic [63:0] d1, input logic b1,
                                      input logic [63:0] d2, input logic b2,
                                      input logic st, input logic err);
    return {d1, b1, d2, b2, st, err};
  endfunction

  function automatic vec_t mk(input logic rstn, input logic [4:0] a1, input logic [4:0] a2,
                              input logic iv, input logic [4:0] ird,
                              input logic we, input logic [4:0] wa, input logic [63:0] wd,
                              input logic [131:0] e);
    vec_t v;
    v.rstn = rstn; v.a1 = a1; v.a2 = a2; v.iv = iv; v.ird = ird;
    v.we = we; v.wa = wa; v.wd = wd; v.exp = e;
    return v;
  endfunction

  function automatic logic [131:0] obs();
    return {bus.rs1_data_o, bus.rs1_busy_o, bus.rs2_data_o, bus.rs2_busy_o,
            bus.issue_stall_o, bus.wb_err_o};
  endfunction

  // Drive one cycle of stimulus and queue what the outputs must show.
  task automatic apply(input vec_t v, input string tag);
    sb_t s;
    resetn            = v.rstn;
    bus.rs1_addr_i    = v.a1;
    bus.rs2_addr_i    = v.a2;
    bus.issue_valid_i = v.iv;
    bus.issue_rd_i    = v.ird;
    bus.wr_en_i       = v.we;
    bus.wr_addr_i     = v.wa;
    bus.wr_data_i     = v.wd;
    s.tag = tag;
    s.exp = v.exp;
    sb.push_back(s);
  endtask

  task automatic test_reset;
    vec_t q[$];
    sb_t e;
    logic [131:0] o;
    q.push_back(mk(0, 5, 0, 0, 0, 0, 0, 0, ex(0, 0, 0, 0, 0, 0)));
    q.push_back(mk(1, 5, 0, 0, 0, 0, 0, 0, ex(0, 0, 0, 0, 0, 0)));
    foreach (q[i]) begin
      apply(q[i], $sformatf("reset[%0d]", i));
      @(negedge clk);
      e = sb.pop_front();
      o = obs();
      n_chk++;
      if (o !== e.exp) $display("FAIL %s: got %h expected %h", e.tag, o, e.exp);
      else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_bypass;
    vec_t q[$];
    sb_t e;
    logic [131:0] o;
    q.push_back(mk(1, 7, 0, 1, 7, 0, 0, 0,  ex(0,  0, 0,  0, 0, 0)));
    q.push_back(mk(1, 7, 0, 0, 0, 0, 0, 0,  ex(0,  1, 0,  0, 0, 0)));
    q.push_back(mk(1, 7, 0, 0, 0, 1, 7, V7, ex(V7, 0, 0,  0, 0, 0)));
    q.push_back(mk(1, 7, 7, 0, 0, 0, 0, 0,  ex(V7, 0, V7, 0, 0, 0)));
    foreach (q[i]) begin
      apply(q[i], $sformatf("bypass[%0d]", i));
      @(negedge clk);
      e = sb.pop_front();
      o = obs();
      n_chk++;
      if (o !== e.exp) $display("FAIL %s: got %h expected %h", e.tag, o, e.exp);
      else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_x0;
    vec_t q[$];
    sb_t e;
    logic [131:0] o;
    q.push_back(mk(1, 0, 0, 1, 0, 1, 0, 64'hFFFF_FFFF_FFFF_FFFF, ex(0, 0, 0,  0, 0, 0)));
    q.push_back(mk(1, 0, 7, 1, 0, 0, 0, 0,                      ex(0, 0, V7, 0, 0, 0)));
    foreach (q[i]) begin
      apply(q[i], $sformatf("x0[%0d]", i));
      @(negedge clk);
      e = sb.pop_front();
      o = obs();
      n_chk++;
      if (o !== e.exp) $display("FAIL %s: got %h expected %h", e.tag, o, e.exp);
      else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_saturate;
    vec_t q[$];
    sb_t e;
    logic [131:0] o;
    q.push_back(mk(1, 3, 0, 1, 3, 0, 0, 0,  ex(0,  0, 0, 0, 0, 0)));
    q.push_back(mk(1, 3, 0, 1, 3, 0, 0, 0,  ex(0,  1, 0, 0, 0, 0)));
    q.push_back(mk(1, 3, 0, 1, 3, 0, 0, 0,  ex(0,  1, 0, 0, 0, 0)));
    q.push_back(mk(1, 3, 0, 1, 3, 0, 0, 0,  ex(0,  1, 0, 0, 1, 0)));
    q.push_back(mk(1, 3, 0, 1, 3, 0, 0, 0,  ex(0,  1, 0, 0, 1, 0)));
    q.push_back(mk(1, 3, 0, 1, 3, 1, 3, V3, ex(V3, 1, 0, 0, 0, 0)));
    q.push_back(mk(1, 3, 0, 1, 3, 0, 0, 0,  ex(V3, 1, 0, 0, 1, 0)));
    foreach (q[i]) begin
      apply(q[i], $sformatf("saturate[%0d]", i));
      @(negedge clk);
      e = sb.pop_front();
      o = obs();
      n_chk++;
      if (o !== e.exp) $display("FAIL %s: got %h expected %h", e.tag, o, e.exp);
      else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_multi_pending;
    vec_t q[$];
    sb_t e;
    logic [131:0] o;
    q.push_back(mk(1, 9, 0, 1, 9, 0, 0, 0,     ex(0, 0, 0, 0, 0, 0)));
    q.push_back(mk(1, 9, 0, 1, 9, 0, 0, 0,     ex(0, 1, 0, 0, 0, 0)));
    q.push_back(mk(1, 9, 9, 0, 0, 1, 9, 64'h1, ex(1, 1, 1, 1, 0, 0)));
    q.push_back(mk(1, 9, 0, 0, 0, 1, 9, 64'h2, ex(2, 0, 0, 0, 0, 0)));
    q.push_back(mk(1, 9, 0, 0, 0, 0, 0, 0,     ex(2, 0, 0, 0, 0, 0)));
    foreach (q[i]) begin
      apply(q[i], $sformatf("multi_pending[%0d]", i));
      @(negedge clk);
      e = sb.pop_front();
      o = obs();
      n_chk++;
      if (o !== e.exp) $display("FAIL %s: got %h expected %h", e.tag, o, e.exp);
      else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  // The reset vector lowers resetn 1 time unit after a rising edge, so the
  // sample at the following falling edge sees the asynchronous clear.
  task automatic test_err_reset;
    vec_t q[$];
    sb_t e;
    logic [131:0] o;
    q.push_back(mk(1, 12, 0, 0, 0, 1, 12, V12, ex(V12, 0, 0,  0, 0, 0)));
    q.push_back(mk(1, 12, 3, 0, 0, 0, 0,  0,   ex(V12, 0, V3, 1, 0, 1)));
    q.push_back(mk(1, 0,  3, 0, 0, 0, 0,  0,   ex(0,   0, V3, 1, 0, 1)));
    q.push_back(mk(0, 12, 3, 0, 0, 0, 0,  0,   ex(0,   0, 0,  0, 0, 0)));
    q.push_back(mk(1, 7,  3, 1, 3, 0, 0,  0,   ex(0,   0, 0,  0, 0, 0)));
    q.push_back(mk(1, 9,  3, 0, 0, 0, 0,  0,   ex(0,   0, 0,  1, 0, 0)));
    foreach (q[i]) begin
      apply(q[i], $sformatf("err_reset[%0d]", i));
      @(negedge clk);
      e = sb.pop_front();
      o = obs();
      n_chk++;
      if (o !== e.exp) $display("FAIL %s: got %h expected %h", e.tag, o, e.exp);
      else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, %0d/%0d checks passed so far", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_bypass();
    test_x0();
    test_saturate();
    test_multi_pending();
    test_err_reset();
    n_chk++;
    if (sb.size() != 0) $display("FAIL scoreboard_drain: got %0d left, expected 0", sb.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
